hazard_ctrl: RTL and testbench

Parametrised next-generation hazard controller for the pipelined RV32I core. It provides load-use and ID-stage branch-operand interlocks with an x0 exemption and per-operand use qualifiers. It also adds a data-memory wait-state freeze with a sequential watchdog, and branch-taken flushing. It sits beside the pipeline registers and drives their PCWrite/stall/flush controls.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / ID-branch interlocks, data-memory freeze with watchdog, taken-branch flush.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              use_rs1_ID,
  input  logic              use_rs2_ID,
  input  logic              branch_ID,
  input  logic              branch_taken_ID,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic              MemRead_MEM,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_MEM,
  output logic              stall_MEM_WB,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              flush_MEM_WB,
  output logic              watchdog_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  // Wait counter must hold MAX_WAIT-1; with the watchdog off it simply saturates.
  localparam int unsigned     WCNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
  localparam bit              WDOG_EN   = (MAX_WAIT != 0);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                wd_err_q, wd_err_d;

  logic mem_stall;
  logic ex_nz, mem_nz;
  logic hit_ex, hit_mem;
  logic load_use, br_haz;

  assign mem_stall = MemRead_MEM & ~mem_ready;
  assign ex_nz     = (rd_EX != '0);
  assign mem_nz    = (rd_MEM != '0);
  assign hit_ex    = (use_rs1_ID & (rs1_ID == rd_EX)) | (use_rs2_ID & (rs2_ID == rd_EX));
  assign hit_mem   = (use_rs1_ID & (rs1_ID == rd_MEM)) | (use_rs2_ID & (rs2_ID == rd_MEM));
  assign load_use  = MemRead_EX & ex_nz & hit_ex;
  assign br_haz    = branch_ID & ((RegWrite_EX & ex_nz & hit_ex) | (MemRead_MEM & mem_nz & hit_mem));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      wd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wd_err_q   <= wd_err_d;
    end
  end

  // Next state plus pipeline controls; controls are combinational on state and inputs.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wd_err_d     = wd_err_q;
    PCWrite      = 1'b1;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    flush_MEM_WB = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (WDOG_EN && (wait_cnt_q >= WAIT_LAST)) begin
          state_d  = HALT;
          wd_err_d = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase

    if (rst) begin
      PCWrite      = 1'b0;
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (state_q == HALT) begin
      PCWrite      = 1'b0;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
    end else if (mem_stall) begin
      PCWrite      = 1'b0;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (load_use || br_haz) begin
      PCWrite     = 1'b0;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (branch_taken_ID) begin
      flush_IF_ID = 1'b1;
    end
  end

  assign watchdog_err = wd_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!PCWrite && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (instantiated with MAX_WAIT=4).
module tb_hazard_ctrl;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 16;

  // Control vector: {PCWrite, stall IF_ID,ID_EX,EX_MEM,MEM_WB, flush IF_ID,ID_EX,EX_MEM,MEM_WB}
  localparam logic [8:0] C_IDLE   = 9'b1_0000_0000;
  localparam logic [8:0] C_RESET  = 9'b0_0000_1111;
  localparam logic [8:0] C_BUBBLE = 9'b0_1000_0100;
  localparam logic [8:0] C_FREEZE = 9'b0_1110_0001;
  localparam logic [8:0] C_HALT   = 9'b0_1111_0000;
  localparam logic [8:0] C_TAKEN  = 9'b1_0000_1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic              use_rs1_ID, use_rs2_ID, branch_ID, branch_taken_ID;
  logic              RegWrite_EX, MemRead_EX, MemRead_MEM, mem_ready;
  logic              PCWrite;
  logic              stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic              flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic              watchdog_err;
  logic [CNT_W-1:0]  stall_cycles;
  logic [8:0]        ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .branch_ID(branch_ID), .branch_taken_ID(branch_taken_ID),
    .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .rd_MEM(rd_MEM), .MemRead_MEM(MemRead_MEM), .mem_ready(mem_ready),
    .PCWrite(PCWrite),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .watchdog_err(watchdog_err), .stall_cycles(stall_cycles)
  );

  assign ctl = {PCWrite, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0; rd_MEM = '0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; branch_ID = 1'b0; branch_taken_ID = 1'b0;
    RegWrite_EX = 1'b0; MemRead_EX = 1'b0; MemRead_MEM = 1'b0; mem_ready = 1'b1;
  endtask

  // Advance past the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    check("reset_ctl", 32'(ctl), 32'(C_RESET));
    check("reset_wdog", 32'(watchdog_err), 32'd0);
    check("reset_cnt", 32'(stall_cycles), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1 check("run_idle", 32'(ctl), 32'(C_IDLE));

    // Load-use on rs2, bubble for exactly one cycle
    tick(); MemRead_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1;
    #1 check("load_use", 32'(ctl), 32'(C_BUBBLE));
    tick(); idle();
    #1 check("load_use_clear", 32'(ctl), 32'(C_IDLE));
    tick(); MemRead_EX = 1'b1; rd_EX = 5'd0; rs2_ID = 5'd0; use_rs2_ID = 1'b1;
    #1 check("load_use_x0", 32'(ctl), 32'(C_IDLE));
    tick(); idle(); MemRead_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; use_rs1_ID = 1'b0;
    #1 check("unused_rs1", 32'(ctl), 32'(C_IDLE));
    tick(); idle(); RegWrite_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
    #1 check("alu_dep_no_branch", 32'(ctl), 32'(C_IDLE));

    // Branch operand hazards, then a taken branch once they clear
    tick(); idle(); branch_ID = 1'b1; RegWrite_EX = 1'b1; rd_EX = 5'd3; rs1_ID = 5'd3; use_rs1_ID = 1'b1;
    #1 check("br_haz_ex", 32'(ctl), 32'(C_BUBBLE));
    tick(); RegWrite_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd3; mem_ready = 1'b1;
    branch_taken_ID = 1'b1;
    #1 check("br_haz_mem_taken_ignored", 32'(ctl), 32'(C_BUBBLE));
    tick(); MemRead_MEM = 1'b0; rd_MEM = 5'd0;
    #1 check("br_taken_flush", 32'(ctl), 32'(C_TAKEN));
    tick(); idle(); branch_ID = 1'b1; RegWrite_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
    #1 check("br_haz_x0", 32'(ctl), 32'(C_IDLE));
    tick(); idle(); branch_ID = 1'b1; RegWrite_EX = 1'b1; rd_EX = 5'd4; rs2_ID = 5'd4; use_rs2_ID = 1'b0;
    #1 check("br_unused_rs2", 32'(ctl), 32'(C_IDLE));

    // Memory wait of three cycles, then ready
    tick(); idle();
    do_reset();
    MemRead_MEM = 1'b1; mem_ready = 1'b0;
    #1 check("memwait_c1", 32'(ctl), 32'(C_FREEZE));
    tick(); MemRead_EX = 1'b1; rd_EX = 5'd2; rs1_ID = 5'd2; use_rs1_ID = 1'b1; branch_taken_ID = 1'b1;
    #1 check("memwait_c2_priority", 32'(ctl), 32'(C_FREEZE));
    tick(); MemRead_EX = 1'b0; branch_taken_ID = 1'b0;
    #1 check("memwait_c3", 32'(ctl), 32'(C_FREEZE));
    tick(); mem_ready = 1'b1;
    #1 check("memwait_ready", 32'(ctl), 32'(C_IDLE));
    tick(); idle();
    #1 check("memwait_run", 32'(ctl), 32'(C_IDLE));
    check("memwait_wdog", 32'(watchdog_err), 32'd0);
`ifdef HAZARD_PERF_EN
    check("memwait_cnt", 32'(stall_cycles), 32'd3);
`else
    check("memwait_cnt", 32'(stall_cycles), 32'd0);
`endif
    // Ready on first MEM cycle: no freeze and no lingering wait state
    tick(); MemRead_MEM = 1'b1; mem_ready = 1'b1;
    #1 check("load_ready_first", 32'(ctl), 32'(C_IDLE));
    tick(); idle();
    #1 check("load_ready_after", 32'(ctl), 32'(C_IDLE));

    // Watchdog: four not-ready cycles reach HALT
    tick(); MemRead_MEM = 1'b1; mem_ready = 1'b0;
    #1 check("wd_c1", 32'(ctl), 32'(C_FREEZE));
    tick(); tick(); tick();
    #1 check("wd_c4", 32'(ctl), 32'(C_FREEZE));
    check("wd_c4_err", 32'(watchdog_err), 32'd0);
    tick();
    #1 check("wd_halt", 32'(ctl), 32'(C_HALT));
    check("wd_halt_err", 32'(watchdog_err), 32'd1);
    mem_ready = 1'b1; MemRead_MEM = 1'b0; branch_taken_ID = 1'b1;
    tick(); tick();
    #1 check("wd_halt_sticky", 32'(ctl), 32'(C_HALT));
    check("wd_err_sticky", 32'(watchdog_err), 32'd1);

    // Asynchronous reset out of HALT, between edges
    #1 rst = 1'b1;
    #1 check("areset_halt_err", 32'(watchdog_err), 32'd0);
    check("areset_halt_ctl", 32'(ctl), 32'(C_RESET));
    tick(); idle(); rst = 1'b0;
    #1 check("areset_halt_run", 32'(ctl), 32'(C_IDLE));

    // Asynchronous reset in the middle of MEM_WAIT
    tick(); MemRead_MEM = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    #1 rst = 1'b1;
    #1 check("areset_mw_err", 32'(watchdog_err), 32'd0);
    check("areset_mw_ctl", 32'(ctl), 32'(C_RESET));
    check("areset_mw_cnt", 32'(stall_cycles), 32'd0);
    idle();
    tick(); #2 rst = 1'b0;
    #1 check("areset_mw_run", 32'(ctl), 32'(C_IDLE));
    // Back in RUN: three further not-ready cycles must not halt (wait count restarted)
    tick(); MemRead_MEM = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    #1 check("post_reset_wait", 32'(ctl), 32'(C_FREEZE));
    check("post_reset_err", 32'(watchdog_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
